// File: rtl/qerv_mem_seq_pkg.sv
// Shared types and helpers for the load/store sequencer and the load-data aligner.
package qerv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ADDR  = 2'b01,
        ST_CHECK = 2'b10,
        ST_REQ   = 2'b11
    } state_e;

    // Access size codes; 2'b11 is handled as a word everywhere.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Byte-lane select for an access of the given size at address bits [1:0].
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] sel;
        case (size)
            SZ_B:    sel = 4'b0001 << lsb;
            SZ_H:    sel = 4'b0011 << lsb;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    // Halves need bit 0 clear, words need both address bits clear.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lsb[0];
            default: mis = |lsb;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/qerv_mem_seq_if.sv
// Single-transfer data-bus handshake between the sequencer and the dbus.
interface qerv_mem_seq_if;
    import qerv_mem_pkg::*;

    logic       o_dbus_cyc;
    logic       o_dbus_we;
    logic [3:0] o_dbus_sel;
    logic       i_dbus_ack;

    modport master (
        output o_dbus_cyc,
        output o_dbus_we,
        output o_dbus_sel,
        input  i_dbus_ack
    );

    modport slave (
        input  o_dbus_cyc,
        input  o_dbus_we,
        input  o_dbus_sel,
        output i_dbus_ack
    );

endinterface

// File: rtl/qerv_mem_seq.sv
// Load/store sequencer: address phase on the buffer register, alignment check,
// then one dbus transfer. Reports done, or done+misalign as a trap.
module qerv_mem_seq
    import qerv_mem_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4,
    parameter int CNT_W          = $clog2(32 / BITS_PER_CYCLE)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_store,
    input  logic [1:0]             i_size,
    input  logic [1:0]             i_lsb,
    qerv_mem_seq_if.master         dbus,
    output logic                   o_bufreg_en,
    output logic                   o_bufreg_init,
    output logic                   o_cnt0,
    output logic                   o_cnt1,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_misalign
);

    localparam int unsigned      N        = 32 / BITS_PER_CYCLE;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             store_q, store_d;
    logic [1:0]       size_q, size_d;

    logic             mis_now;

    // Next-state and counter logic; the counter wraps to 0 at N-1 on its own.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        store_d = store_q;
        size_d  = size_q;
        mis_now = misaligned(size_q, i_lsb);
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    store_d = i_store;
                    size_d  = i_size;
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = mis_now ? ST_IDLE : ST_REQ;
            end
            ST_REQ: begin
                if (dbus.i_dbus_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous abort.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            store_q <= 1'b0;
            size_q  <= SZ_B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            size_q  <= size_d;
        end
    end

    // Output decode: state-driven except done (ack/lsb) and lane select (lsb).
    always_comb begin
        o_bufreg_en     = (state_q == ST_ADDR);
        o_bufreg_init   = (state_q == ST_ADDR);
        o_cnt0          = (state_q == ST_ADDR) && (cnt_q == '0);
        o_cnt1          = (state_q == ST_ADDR) && (cnt_q == CNT_ONE);
        o_busy          = (state_q != ST_IDLE);
        dbus.o_dbus_cyc = (state_q == ST_REQ);
        dbus.o_dbus_we  = (state_q == ST_REQ) && store_q;
        dbus.o_dbus_sel = (state_q == ST_REQ) ? lane_sel(size_q, i_lsb) : '0;
        o_misalign      = (state_q == ST_CHECK) && mis_now;
        o_done          = o_misalign || ((state_q == ST_REQ) && dbus.i_dbus_ack);
    end

endmodule
